// File: rtl/bcd_conv_sched_pkg.sv
// Shared widths and FSM state type for the bin2BCD request scheduler.
package bcd_sched_pkg;

    localparam int BIN_W = 12;
    localparam int BCD_W = 16;
    localparam int ID_W  = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/bcd_conv_sched_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 3
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic             valid,
    output logic [ID_W-1:0]  idx
);

    logic [N_REQ-1:0] rot;
    logic [ID_W:0]    sum;
    logic             found;

    // Rotate so bit 0 is the requester at ptr, then map the offset back to an index.
    always_comb begin
        rot   = N_REQ'({req, req} >> ptr);
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            if (!found && rot[j]) begin
                found = 1'b1;
                sum   = {1'b0, ptr} + (ID_W+1)'(j);
                if (sum >= (ID_W+1)'(N_REQ)) begin
                    sum = sum - (ID_W+1)'(N_REQ);
                end
                idx = sum[ID_W-1:0];
            end
        end
        valid = found;
    end

endmodule

// File: rtl/bcd_conv_sched.sv
// Round-robin scheduler sharing one external bin2BCD converter among N_REQ requesters.
module bcd_conv_sched
    import bcd_sched_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 63
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*BIN_W-1:0] req_data,
    output logic [N_REQ-1:0]       ack,
    output logic [BCD_W-1:0]       res_bcd,
    output logic [ID_W-1:0]        res_id,
    output logic                   res_err,
    output logic                   busy,
    output logic                   conv_en,
    output logic [BIN_W-1:0]       conv_bin,
    input  logic [BCD_W-1:0]       conv_bcd,
    input  logic                   conv_rdy
);

    state_t             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    cur_id_q, cur_id_d;
    logic [7:0]         tmr_q, tmr_d;
    logic [BIN_W-1:0]   conv_bin_q, conv_bin_d;
    logic [BCD_W-1:0]   res_bcd_q, res_bcd_d;
    logic [ID_W-1:0]    res_id_q, res_id_d;
    logic               res_err_q, res_err_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic               busy_q, busy_d;
    logic               conv_en_q, conv_en_d;

    logic               pick_valid;
    logic [ID_W-1:0]    pick_idx;
    logic [BIN_W-1:0]   pick_data;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        pick_data = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (pick_idx == ID_W'(i)) begin
                pick_data = req_data[i*BIN_W +: BIN_W];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cur_id_d   = cur_id_q;
        tmr_d      = tmr_q;
        conv_bin_d = conv_bin_q;
        res_bcd_d  = res_bcd_q;
        res_err_d  = res_err_q;
        res_id_d   = res_id_q;

        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    cur_id_d   = pick_idx;
                    conv_bin_d = pick_data;
                    state_d    = S_START;
                end
            end
            S_START: begin
                tmr_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (conv_rdy) begin
                    res_bcd_d = conv_bcd;
                    res_err_d = 1'b0;
                    state_d   = S_DONE;
                end else if (tmr_q == 8'(TIMEOUT)) begin
                    res_bcd_d = '0;
                    res_err_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    tmr_d = tmr_q + 8'd1;
                end
            end
            S_DONE: begin
                ptr_d   = (cur_id_q == ID_W'(N_REQ-1)) ? '0 : cur_id_q + 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Status outputs are registered against the state being entered.
        busy_d    = (state_d != S_IDLE);
        conv_en_d = (state_d == S_START);
        for (int unsigned i = 0; i < N_REQ; i++) begin
            ack_d[i] = (state_d == S_DONE) && (cur_id_q == ID_W'(i));
        end
        if (state_d == S_DONE) begin
            res_id_d = cur_id_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            cur_id_q   <= '0;
            tmr_q      <= '0;
            conv_bin_q <= '0;
            res_bcd_q  <= '0;
            res_id_q   <= '0;
            res_err_q  <= 1'b0;
            ack_q      <= '0;
            busy_q     <= 1'b0;
            conv_en_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cur_id_q   <= cur_id_d;
            tmr_q      <= tmr_d;
            conv_bin_q <= conv_bin_d;
            res_bcd_q  <= res_bcd_d;
            res_id_q   <= res_id_d;
            res_err_q  <= res_err_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            conv_en_q  <= conv_en_d;
        end
    end

    assign ack      = ack_q;
    assign res_bcd  = res_bcd_q;
    assign res_id   = res_id_q;
    assign res_err  = res_err_q;
    assign busy     = busy_q;
    assign conv_en  = conv_en_q;
    assign conv_bin = conv_bin_q;

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Directed bench for bcd_conv_sched with a transaction-level reference and converter model.
module tb_bcd_conv_sched;

    localparam int N   = 4;
    localparam int TMO = 63;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [N*12-1:0] req_data;
    logic [N-1:0]  ack;
    logic [15:0]   res_bcd;
    logic [2:0]    res_id;
    logic          res_err, busy, conv_en;
    logic [11:0]   conv_bin;
    logic [15:0]   conv_bcd;
    logic          conv_rdy;

    logic [3:0]    pk_req;
    logic [2:0]    pk_ptr;
    logic          pk_valid;
    logic [2:0]    pk_idx;

    always #5 clk = ~clk;

    bcd_conv_sched #(.N_REQ(N), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .ack(ack), .res_bcd(res_bcd), .res_id(res_id), .res_err(res_err),
        .busy(busy), .conv_en(conv_en), .conv_bin(conv_bin),
        .conv_bcd(conv_bcd), .conv_rdy(conv_rdy)
    );

    rr_pick #(.N_REQ(4), .ID_W(3)) u_pick (
        .req(pk_req), .ptr(pk_ptr), .valid(pk_valid), .idx(pk_idx)
    );

    typedef struct {
        int id;
        int data;
        bit err;
        int lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   conv_lat = 14;
    int   n_acks = 0;
    int   log_id[64];
    int   log_bcd[64];
    int   log_err[64];
    int   log_cyc[64];
    int   hold_cnt[N];

    bit          in_flight = 1'b0;
    int          en_cyc = 0;
    logic [15:0] last_bcd = '0;
    logic [2:0]  last_id = '0;
    logic        last_err = 1'b0;
    exp_t        e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic fail(input string name, input logic [31:0] act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got %0h, expected nothing (cycle %0d)", name, act, cyc);
    endtask

    function automatic int to_bcd(input int v);
        return (v / 1000) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + v % 10;
    endfunction

    function automatic int rr_ref(input int r, input int p);
        for (int k = 0; k < N; k++) begin
            int c;
            c = (p + k) % N;
            if (((r >> c) & 1) == 1) return c;
        end
        return -1;
    endfunction

    // Converter stand-in: strobes rdy L+1 cycles after the start pulse; negative L never answers.
    initial begin
        conv_rdy = 1'b0;
        conv_bcd = 16'hBEEF;
        forever begin
            @(posedge clk);
            #1;
            if (conv_en && conv_lat >= 0) begin
                int v;
                int l;
                v = int'(conv_bin);
                l = conv_lat;
                repeat (l + 1) @(posedge clk);
                #1;
                conv_rdy = 1'b1;
                conv_bcd = 16'(to_bcd(v));
                @(posedge clk);
                #1;
                conv_rdy = 1'b0;
                conv_bcd = 16'hBEEF;
            end
        end
    end

    // Every-cycle compare against the expected-transaction queue.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (rst) begin
                exp_q.delete();
                in_flight = 1'b0;
                last_bcd  = '0;
                last_id   = '0;
                last_err  = 1'b0;
            end else begin
                if (conv_en) begin
                    check("start_while_busy", 32'(in_flight), 32'd0);
                    in_flight = 1'b1;
                    en_cyc    = cyc;
                    if (exp_q.size() == 0) fail("unexpected_grant", 32'(conv_bin));
                    else check("conv_bin_at_start", 32'(conv_bin), exp_q[0].data);
                end
                check("busy", 32'(busy), 32'(in_flight));
                if (in_flight && exp_q.size() > 0)
                    check("conv_bin_hold", 32'(conv_bin), exp_q[0].data);
                if (ack != '0) begin
                    if (!in_flight || exp_q.size() == 0) begin
                        fail("unexpected_ack", 32'(ack));
                    end else begin
                        e = exp_q.pop_front();
                        check("ack_onehot", 32'(ack), 32'(1 << e.id));
                        check("res_id", 32'(res_id), e.id);
                        check("res_err", 32'(res_err), 32'(e.err));
                        check("res_bcd", 32'(res_bcd), e.err ? 0 : to_bcd(e.data));
                        check("ack_latency", cyc - en_cyc, e.err ? TMO + 2 : e.lat + 2);
                        check("conv_en_at_ack", 32'(conv_en), 32'd0);
                        if (n_acks < 64) begin
                            log_id[n_acks]  = int'(res_id);
                            log_bcd[n_acks] = int'(res_bcd);
                            log_err[n_acks] = int'(res_err);
                            log_cyc[n_acks] = cyc;
                        end
                        n_acks++;
                        last_bcd  = res_bcd;
                        last_id   = res_id;
                        last_err  = res_err;
                        in_flight = 1'b0;
                    end
                end else begin
                    check("res_bcd_hold", 32'(res_bcd), 32'(last_bcd));
                    check("res_id_hold", 32'(res_id), 32'(last_id));
                    check("res_err_hold", 32'(res_err), 32'(last_err));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

    // Requesters drop req right after their ack unless asked to re-assert.
    task automatic step();
        @(posedge clk);
        #2;
        for (int i = 0; i < N; i++) begin
            if (ack[i]) begin
                if (hold_cnt[i] > 0) hold_cnt[i]--;
                else req[i] = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_acks(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (n_acks < target && k < budget) begin
            step();
            k++;
        end
        if (n_acks < target) check(name, n_acks, target);
    endtask

    task automatic push(input int id, input int data, input bit err);
        exp_q.push_back('{id, data, err, conv_lat});
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ack"}, 32'(ack), 32'd0);
        check({tag, "_res_bcd"}, 32'(res_bcd), 32'd0);
        check({tag, "_res_id"}, 32'(res_id), 32'd0);
        check({tag, "_res_err"}, 32'(res_err), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_conv_en"}, 32'(conv_en), 32'd0);
        check({tag, "_conv_bin"}, 32'(conv_bin), 32'd0);
    endtask

    initial begin
        int t0;
        int base;
        int k;
        int r;
        rst      = 1'b1;
        req      = '0;
        req_data = '0;
        pk_req   = '0;
        pk_ptr   = '0;
        for (int i = 0; i < N; i++) hold_cnt[i] = 0;

        for (int p = 0; p < 4; p++) begin
            for (int q = 0; q < 16; q++) begin
                pk_req = 4'(q);
                pk_ptr = 3'(p);
                #1;
                r = rr_ref(q, p);
                check("pick_valid", 32'(pk_valid), 32'(r >= 0));
                if (r >= 0) check("pick_idx", 32'(pk_idx), r);
            end
        end
        pk_req = 4'b0110;
        pk_ptr = 3'd3;
        #1;
        check("pick_wrap_lit", 32'(pk_idx), 32'd1);

        check_outputs_zero("reset");
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        step();

        // Single request, L=14: ack 17 cycles after the grant cycle.
        conv_lat = 14;
        base = n_acks;
        push(0, 1234, 1'b0);
        req_data[11:0] = 12'd1234;
        req = 4'b0001;
        t0 = cyc;
        wait_acks(base + 1, 40, "single_wait");
        check("single_ack_cycle", log_cyc[base] - t0, 32'd17);
        check("single_bcd_lit", log_bcd[base], 32'h1234);
        check("single_err_lit", log_err[base], 32'd0);
        idle(2);

        // Timeout, then a normal conversion.
        conv_lat = -1;
        base = n_acks;
        push(0, 555, 1'b1);
        req_data[11:0] = 12'd555;
        req = 4'b0001;
        t0 = cyc;
        wait_acks(base + 1, 100, "timeout_wait");
        check("timeout_ack_cycle", log_cyc[base] - t0, 32'd66);
        check("timeout_err_lit", log_err[base], 32'd1);
        check("timeout_bcd_lit", log_bcd[base], 32'd0);
        idle(2);
        conv_lat = 14;
        base = n_acks;
        push(2, 321, 1'b0);
        req_data[35:24] = 12'd321;
        req = 4'b0100;
        wait_acks(base + 1, 40, "after_timeout_wait");
        check("after_timeout_bcd_lit", log_bcd[base], 32'h0321);
        check("after_timeout_err_lit", log_err[base], 32'd0);
        idle(2);

        // Requester data changes during START; the latched value must be used.
        base = n_acks;
        push(0, 42, 1'b0);
        req_data[11:0] = 12'd42;
        req = 4'b0001;
        k = 0;
        while (!conv_en && k < 5) begin
            step();
            k++;
        end
        check("datachg_start_seen", 32'(conv_en), 32'd1);
        req_data[11:0] = 12'd7;
        wait_acks(base + 1, 40, "datachg_wait");
        check("datachg_bcd_lit", log_bcd[base], 32'h0042);
        check("datachg_conv_bin_lit", 32'(conv_bin), 32'd42);
        idle(2);

        // Reset at cycle 8 of a conversion; the late rdy strobe must be ignored.
        conv_lat = 20;
        base = n_acks;
        push(0, 500, 1'b0);
        req_data[11:0] = 12'd500;
        req = 4'b0001;
        t0 = cyc;
        while (cyc < t0 + 8) step();
        check("midwait_busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        req = '0;
        #1;
        check_outputs_zero("midwait_rst");
        step();
        step();
        rst = 1'b0;
        idle(30);
        check("midwait_no_ack", n_acks, base);
        check("midwait_res_bcd_lit", 32'(res_bcd), 32'd0);

        // Contention from ptr=0: served 0,1,2,3.
        conv_lat = 5;
        base = n_acks;
        req_data = {12'd100, 12'd999, 12'd0, 12'd4095};
        push(0, 4095, 1'b0);
        push(1, 0, 1'b0);
        push(2, 999, 1'b0);
        push(3, 100, 1'b0);
        req = 4'b1111;
        wait_acks(base + 4, 200, "contention_wait");
        check("cont_id0", log_id[base], 32'd0);
        check("cont_id1", log_id[base + 1], 32'd1);
        check("cont_id2", log_id[base + 2], 32'd2);
        check("cont_id3", log_id[base + 3], 32'd3);
        check("cont_bcd0", log_bcd[base], 32'h4095);
        check("cont_bcd1", log_bcd[base + 1], 32'h0000);
        check("cont_bcd2", log_bcd[base + 2], 32'h0999);
        check("cont_bcd3", log_bcd[base + 3], 32'h0100);
        idle(2);

        // Pointer wrapped back to 0: requester 0 beats requester 3.
        base = n_acks;
        req_data[11:0]  = 12'd7;
        req_data[47:36] = 12'd8;
        push(0, 7, 1'b0);
        push(3, 8, 1'b0);
        req = 4'b1001;
        wait_acks(base + 2, 100, "ptr_wait");
        check("ptr_first_lit", log_id[base], 32'd0);
        check("ptr_second_lit", log_id[base + 1], 32'd3);
        idle(2);

        // Fairness: requester 1 re-asserts after its ack; 3 is served first.
        base = n_acks;
        req_data[23:12] = 12'd11;
        req_data[47:36] = 12'd33;
        hold_cnt[1] = 1;
        push(1, 11, 1'b0);
        push(3, 33, 1'b0);
        push(1, 11, 1'b0);
        req = 4'b1010;
        wait_acks(base + 3, 150, "fair_wait");
        check("fair_first_lit", log_id[base], 32'd1);
        check("fair_second_lit", log_id[base + 1], 32'd3);
        check("fair_third_lit", log_id[base + 2], 32'd1);
        idle(3);
        check("final_queue_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
